// File: rtl/float_addsub_pipe_if.sv
// Operand/result handshake bundle for float_addsub_pipe.
// Carries out_flags only when FADD_FLAGS_EN is defined.
interface float_addsub_pipe_if #(
    parameter int unsigned E_BIT = 8,
    parameter int unsigned F_BIT = 23
);
    localparam int unsigned W = 1 + E_BIT + F_BIT;

    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
`ifdef FADD_FLAGS_EN
    logic [3:0]   out_flags;

    modport master (
        output in_valid, op_sub, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );
    modport slave (
        input  in_valid, op_sub, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
`else
    modport master (
        output in_valid, op_sub, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result
    );
    modport slave (
        input  in_valid, op_sub, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result
    );
`endif
endinterface

// File: rtl/float_addsub_pipe.sv
// Three-stage pipelined float add/sub (RNE, flush-to-zero, valid/ready back-pressure).
// Define FADD_FLAGS_EN to add out_flags = {invalid, overflow, underflow, inexact}.
module float_addsub_pipe #(
    parameter int unsigned E_BIT = 8,
    parameter int unsigned F_BIT = 23
) (
    input logic clk,
    input logic rst_n,
    float_addsub_pipe_if.slave bus
);
    localparam int unsigned W   = 1 + E_BIT + F_BIT;
    localparam int unsigned MW  = F_BIT + 4;  // hidden + fraction + guard/round/sticky
    localparam int unsigned SAT = F_BIT + 3;
    localparam int          EMAX = (1 << E_BIT) - 1;
    localparam logic [W-1:0] QNAN = {1'b0, {E_BIT{1'b1}}, 1'b1, {(F_BIT-1){1'b0}}};

    // Stage advance chain; a stage may load when empty or when its content moves on
    logic v1_q, v2_q, v3_q;
    logic adv1, adv2, adv3;

    assign adv3 = !v3_q || bus.out_ready;
    assign adv2 = !v2_q || adv3;
    assign adv1 = !v1_q || adv2;
    assign bus.in_ready  = adv1;
    assign bus.out_valid = v3_q;

    // ---------------- S1: unpack, specials, swap, align ----------------
    logic             sa, sb;
    logic [E_BIT-1:0] ea, eb, big_e, sml_e, diff;
    logic [F_BIT-1:0] fa, fb, big_f, sml_f;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge, big_s;
    logic             s1_sp, s1_inv;
    logic [W-1:0]     s1_res;
    logic [2*MW-1:0]  wide;
    logic [MW-1:0]    big_m, sml_m;
    int unsigned      sh;

    always_comb begin
        sa     = bus.in_a[W-1];
        sb     = bus.in_b[W-1] ^ bus.op_sub;
        ea     = bus.in_a[W-2:F_BIT];
        eb     = bus.in_b[W-2:F_BIT];
        fa     = bus.in_a[F_BIT-1:0];
        fb     = bus.in_b[F_BIT-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_nan  = (&ea) && (fa != '0);
        b_nan  = (&eb) && (fb != '0);
        a_inf  = (&ea) && (fa == '0);
        b_inf  = (&eb) && (fb == '0);

        s1_sp  = 1'b1;
        s1_inv = 1'b0;
        s1_res = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            s1_res = QNAN;
            s1_inv = 1'b1;
        end else if (a_inf) begin
            s1_res = {sa, {E_BIT{1'b1}}, {F_BIT{1'b0}}};
        end else if (b_inf) begin
            s1_res = {sb, {E_BIT{1'b1}}, {F_BIT{1'b0}}};
        end else if (a_zero && b_zero) begin
            s1_res = {sa && sb, {(W-1){1'b0}}};
        end else if (a_zero) begin
            s1_res = {sb, bus.in_b[W-2:0]};
        end else if (b_zero) begin
            s1_res = bus.in_a;
        end else begin
            s1_sp = 1'b0;
        end

        a_ge  = {ea, fa} >= {eb, fb};
        big_s = a_ge ? sa : sb;
        big_e = a_ge ? ea : eb;
        big_f = a_ge ? fa : fb;
        sml_e = a_ge ? eb : ea;
        sml_f = a_ge ? fb : fa;
        diff  = big_e - sml_e;
        sh    = (32'(diff) > SAT) ? SAT : 32'(diff);
        // Low half of the wide shift collects everything pushed past the sticky bit
        wide  = {1'b1, sml_f, 3'b000, {MW{1'b0}}} >> sh;
        sml_m = wide[2*MW-1:MW] | {{(MW-1){1'b0}}, |wide[MW-1:0]};
        big_m = {1'b1, big_f, 3'b000};
    end

    logic             sp1_q, sign1_q, sub1_q;
    logic [W-1:0]     res1_q;
    logic [E_BIT-1:0] exp1_q;
    logic [MW-1:0]    bigm1_q, smlm1_q;

    // ---------------- S2: mantissa add/subtract ----------------
    logic             sp2_q, sign2_q;
    logic [W-1:0]     res2_q;
    logic [E_BIT-1:0] exp2_q;
    logic [MW:0]      sum2_q;
    logic [MW:0]      s2_sum;

    assign s2_sum = sub1_q ? ({1'b0, bigm1_q} - {1'b0, smlm1_q})
                           : ({1'b0, bigm1_q} + {1'b0, smlm1_q});

    // ---------------- S3: normalise, round, pack ----------------
    logic [MW-1:0]  norm;
    logic [F_BIT:0] mr;
    logic           rnd;
    int             lz, exp_n;
    logic           found;
    logic [W-1:0]   s3_res;
    logic [W-1:0]   res3_q;
`ifdef FADD_FLAGS_EN
    logic           inv1_q, inv2_q;
    logic [3:0]     s3_flags, flags3_q;
`endif

    always_comb begin
        lz    = 0;
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found && sum2_q[i]) begin
                lz    = MW - 1 - i;
                found = 1'b1;
            end
        end
        if (sum2_q[MW]) begin
            norm  = {sum2_q[MW:2], sum2_q[1] | sum2_q[0]};
            exp_n = int'(exp2_q) + 1;
        end else begin
            norm  = sum2_q[MW-1:0] << lz;
            exp_n = int'(exp2_q) - lz;
        end
        rnd = norm[2] && (norm[1] || norm[0] || norm[3]);
        mr  = {1'b0, norm[MW-2:3]} + {{F_BIT{1'b0}}, rnd};
        if (mr[F_BIT]) begin
            exp_n = exp_n + 1;
        end

`ifdef FADD_FLAGS_EN
        s3_flags = {3'b000, norm[2] || norm[1] || norm[0]};
`endif
        if (sp2_q) begin
            s3_res = res2_q;
`ifdef FADD_FLAGS_EN
            s3_flags = {inv2_q, 3'b000};
`endif
        end else if (!norm[MW-1]) begin
            s3_res = '0;
`ifdef FADD_FLAGS_EN
            s3_flags = 4'b0000;
`endif
        end else if (exp_n >= EMAX) begin
            s3_res = {sign2_q, {E_BIT{1'b1}}, {F_BIT{1'b0}}};
`ifdef FADD_FLAGS_EN
            s3_flags = 4'b0101;
`endif
        end else if (exp_n < 1) begin
            s3_res = {sign2_q, {(W-1){1'b0}}};
`ifdef FADD_FLAGS_EN
            s3_flags = 4'b0011;
`endif
        end else begin
            s3_res = {sign2_q, exp_n[E_BIT-1:0], mr[F_BIT-1:0]};
        end
    end

    assign bus.out_result = res3_q;
`ifdef FADD_FLAGS_EN
    assign bus.out_flags = flags3_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            sp1_q   <= 1'b0;
            sign1_q <= 1'b0;
            sub1_q  <= 1'b0;
            res1_q  <= '0;
            exp1_q  <= '0;
            bigm1_q <= '0;
            smlm1_q <= '0;
            sp2_q   <= 1'b0;
            sign2_q <= 1'b0;
            res2_q  <= '0;
            exp2_q  <= '0;
            sum2_q  <= '0;
            res3_q  <= '0;
`ifdef FADD_FLAGS_EN
            inv1_q   <= 1'b0;
            inv2_q   <= 1'b0;
            flags3_q <= '0;
`endif
        end else begin
            if (adv1) begin
                v1_q <= bus.in_valid;
                if (bus.in_valid) begin
                    sp1_q   <= s1_sp;
                    res1_q  <= s1_res;
                    sign1_q <= big_s;
                    sub1_q  <= sa ^ sb;
                    exp1_q  <= big_e;
                    bigm1_q <= big_m;
                    smlm1_q <= sml_m;
`ifdef FADD_FLAGS_EN
                    inv1_q  <= s1_inv;
`endif
                end
            end
            if (adv2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    sp2_q   <= sp1_q;
                    res2_q  <= res1_q;
                    sign2_q <= sign1_q;
                    exp2_q  <= exp1_q;
                    sum2_q  <= s2_sum;
`ifdef FADD_FLAGS_EN
                    inv2_q  <= inv1_q;
`endif
                end
            end
            if (adv3) begin
                v3_q <= v2_q;
                if (v2_q) begin
                    res3_q <= s3_res;
`ifdef FADD_FLAGS_EN
                    flags3_q <= s3_flags;
`endif
                end
            end
        end
    end

`ifndef FADD_FLAGS_EN
    // Invalid detection only feeds the flag output
    logic unused_inv;
    assign unused_inv = s1_inv;
`endif
endmodule

// File: tb/tb_float_addsub_pipe.sv
// Self-checking bench for float_addsub_pipe: vector table + scoreboard, back-pressure,
// async reset and a half-precision instance.
module tb_float_addsub_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    float_addsub_pipe_if #(.E_BIT(8), .F_BIT(23)) bus ();
    float_addsub_pipe #(.E_BIT(8), .F_BIT(23)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    float_addsub_pipe_if #(.E_BIT(5), .F_BIT(10)) hbus ();
    float_addsub_pipe #(.E_BIT(5), .F_BIT(10)) hdut (.clk(clk), .rst_n(rst_n), .bus(hbus));

    typedef struct {
        logic        sub;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic add_vec(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic [3:0] f);
        vecs.push_back('{sub: s, a: a, b: b, res: r, fl: f});
    endtask

    // One cycle: drive at negedge, evaluate handshakes 1 time unit later
    task automatic step(input logic v, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [3:0] ef, input logic ordy,
                        output logic acc);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.op_sub    = s;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = ordy;
        #1;
        acc = v && bus.in_ready;
        if (bus.out_valid && ordy) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", bus.out_result, 32'hxxxx_xxxx);
            end else begin
                e = sb_q.pop_front();
                check("result", bus.out_result, e.res);
`ifdef FADD_FLAGS_EN
                check("flags", {28'd0, bus.out_flags}, {28'd0, e.fl});
`endif
            end
        end
        if (acc) sb_q.push_back('{res: er, fl: ef});
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, ordy, acc);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() > 0; i++) idle(1'b1);
        check("drain_empty", sb_q.size(), 0);
    endtask

    task automatic hcase(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [15:0] er);
        @(negedge clk);
        hbus.in_valid = 1'b1;
        hbus.op_sub   = s;
        hbus.in_a     = a;
        hbus.in_b     = b;
        #1;
        check({name, "_accept"}, {31'd0, hbus.in_ready}, 32'd1);
        @(negedge clk);
        hbus.in_valid = 1'b0;
        #1;
        for (int n = 0; n < 10 && !hbus.out_valid; n++) begin
            @(negedge clk);
            #1;
        end
        check({name, "_valid"}, {31'd0, hbus.out_valid}, 32'd1);
        check(name, {16'd0, hbus.out_result}, {16'd0, er});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        logic        acc;
        logic [31:0] bp_a[5];
        logic [31:0] held;
        int          idx;
        int          outs;
        int          stale;

        bus.in_valid   = 1'b0;
        bus.op_sub     = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.out_ready  = 1'b0;
        hbus.in_valid  = 1'b0;
        hbus.op_sub    = 1'b0;
        hbus.in_a      = '0;
        hbus.in_b      = '0;
        hbus.out_ready = 1'b1;

        // {op_sub, a, b, result, {invalid, overflow, underflow, inexact}}
        add_vec(0, 32'h3FC00000, 32'h3FC00000, 32'h40400000, 4'b0000);
        add_vec(1, 32'h3FC00000, 32'h3FC00000, 32'h00000000, 4'b0000);
        add_vec(0, 32'h80000000, 32'h80000000, 32'h80000000, 4'b0000);
        add_vec(0, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001);
        add_vec(0, 32'h3F800001, 32'h33800000, 32'h3F800002, 4'b0001);
        add_vec(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101);
        add_vec(0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000);
        add_vec(0, 32'h7FC12345, 32'h3F800000, 32'h7FC00000, 4'b1000);
        add_vec(0, 32'h00400000, 32'h00000000, 32'h00000000, 4'b0000);
        add_vec(1, 32'h40000000, 32'h3F800000, 32'h3F800000, 4'b0000);
        add_vec(1, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'b0000);
        add_vec(0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0000);
        add_vec(1, 32'h3F800000, 32'hFF800000, 32'h7F800000, 4'b0000);
        add_vec(1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000);
        add_vec(0, 32'h40400000, 32'h3F800000, 32'h40800000, 4'b0000);
        add_vec(0, 32'h3F800000, 32'h00000000, 32'h3F800000, 4'b0000);
        add_vec(1, 32'h00000000, 32'h3F800000, 32'hBF800000, 4'b0000);
        add_vec(0, 32'h3F800000, 32'hBF800000, 32'h00000000, 4'b0000);
        add_vec(1, 32'h00C00000, 32'h00800000, 32'h00000000, 4'b0011);
        add_vec(0, 32'h3F800000, 32'h33C00000, 32'h3F800001, 4'b0001);
        add_vec(0, 32'h3F800000, 32'h33000000, 32'h3F800000, 4'b0001);
        add_vec(1, 32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 4'b0000);
        add_vec(0, 32'h3F800000, 32'h00800000, 32'h3F800000, 4'b0001);
        add_vec(0, 32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0001);
        add_vec(0, 32'h3FFFFFFF, 32'h33800000, 32'h40000000, 4'b0001);

        // Reset state while rst_n is low
        #12;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_result", bus.out_result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Latency: result visible after the third rising edge counting the accepting one
        step(1'b1, 1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000, 1'b1, acc);
        check("lat_accept", {31'd0, acc}, 32'd1);
        idle(1'b1);
        check("lat_edge1", {31'd0, bus.out_valid}, 32'd0);
        idle(1'b1);
        check("lat_edge2", {31'd0, bus.out_valid}, 32'd0);
        idle(1'b1);
        check("lat_edge3", {31'd0, bus.out_valid}, 32'd1);
        check("lat_sb_empty", sb_q.size(), 0);

        // Vector table streamed back to back
        foreach (vecs[i]) begin
            for (int t = 0; t < 10; t++) begin
                step(1'b1, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl,
                     1'b1, acc);
                if (acc) break;
            end
            if (!acc) check("vec_accept", {31'd0, acc}, 32'd1);
        end
        drain(30);

        // Back-pressure: a+a doubles a, i.e. exponent field + 1
        for (int i = 0; i < 5; i++) bp_a[i] = 32'h3F800000 + (32'(i) << 16);
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 1'b0, bp_a[idx], bp_a[idx], bp_a[idx] + 32'h00800000, 4'b0000,
                 1'b0, acc);
            if (acc) idx++;
        end
        check("bp_accepts", idx, 3);
        check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
        held = bus.out_result;
        check("bp_head", held, 32'h40000000);
        idle(1'b0);
        idle(1'b0);
        check("bp_stable", bus.out_result, held);
        outs = 0;
        for (int c = 0; c < 5; c++) begin
            step(idx < 5, 1'b0, bp_a[idx < 5 ? idx : 0], bp_a[idx < 5 ? idx : 0],
                 bp_a[idx < 5 ? idx : 0] + 32'h00800000, 4'b0000, 1'b1, acc);
            if (acc) idx++;
            if (bus.out_valid) outs++;
        end
        check("bp_all_accepted", idx, 5);
        check("bp_burst", outs, 5);
        check("bp_sb_empty", sb_q.size(), 0);

        // Asynchronous reset with two ops in flight
        step(1'b1, 1'b0, 32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, 1'b0, acc);
        step(1'b1, 1'b0, 32'h40400000, 32'h40400000, 32'h40C00000, 4'b0000, 1'b0, acc);
        idle(1'b0);
        idle(1'b0);
        check("rst_pre_valid", {31'd0, bus.out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_async_result", bus.out_result, 32'h0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            idle(1'b1);
            if (bus.out_valid) stale++;
        end
        check("rst_no_stale", stale, 0);
        step(1'b1, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000, 1'b1, acc);
        check("rst_fresh_accept", {31'd0, acc}, 32'd1);
        drain(10);

        // Half-precision instance
        hcase("h_one_plus_one", 16'h3C00, 16'h3C00, 1'b0, 16'h4000);
        hcase("h_1p5_plus_1", 16'h3E00, 16'h3C00, 1'b0, 16'h4100);
        hcase("h_cancel", 16'h3C00, 16'h3C00, 1'b1, 16'h0000);
        hcase("h_overflow", 16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
